// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit:
// op encodings, FSM states and the default datapath width.
package muldiv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift-add (mode=0) or restoring
// shift-subtract (mode=1) on a {hi,lo} double-width accumulator.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic                mode,
   input  logic [2*XLEN-1:0]   acc,
   input  logic [XLEN-1:0]     opnd,
   output logic [2*XLEN-1:0]   acc_nxt,
   output logic                q_bit
);

   logic [XLEN:0] mul_sum;
   logic [XLEN:0] rem_sh;
   logic [XLEN:0] diff;

   always_comb begin
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      // Remainder shifted left, pulling in the next dividend bit from the low half.
      rem_sh  = acc[2*XLEN-1:XLEN-1];
      diff    = rem_sh - {1'b0, opnd};
      q_bit   = 1'b0;
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
      if (mode) begin
         q_bit   = ~diff[XLEN];
         acc_nxt = {(q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS MULT/MULTU/DIV/DIVU with HI/LO; XLEN iterations, done_o one cycle after the last.
// busy_o stalls the pipeline; MULDIV_FAST_MUL_EN makes multiplies single-cycle (IDLE->DONE).
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   input  logic            mthi_i,
   input  logic            mtlo_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   state_e              state;
   logic [CNT_W-1:0]    cnt;
   logic [2*XLEN-1:0]   acc;
   logic [XLEN-1:0]     opnd;
   logic [XLEN-1:0]     a_raw;
   logic                neg_res;
   logic                neg_rem;
   logic                div_zero;
   logic [XLEN-1:0]     hi_r;
   logic [XLEN-1:0]     lo_r;
   logic                busy_r;
   logic                done_r;

   logic                a_neg;
   logic                b_neg;
   logic [XLEN-1:0]     abs_a;
   logic [XLEN-1:0]     abs_b;
   logic [2*XLEN-1:0]   acc_nxt;
   logic                q_bit;
   logic [2*XLEN-1:0]   acc_step;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     quo;
   logic [XLEN-1:0]     rem;
   logic [XLEN-1:0]     res_hi;
   logic [XLEN-1:0]     res_lo;

   // Unsigned ops (op_i[0]=1) never take the negative path.
   always_comb begin
      a_neg = ~op_i[0] & a_i[XLEN-1];
      b_neg = ~op_i[0] & b_i[XLEN-1];
      abs_a = a_neg ? -a_i : a_i;
      abs_b = b_neg ? -b_i : b_i;
   end

   muldiv_step #(.XLEN(XLEN)) u_step (
      .mode    (state == ST_DIV),
      .acc     (acc),
      .opnd    (opnd),
      .acc_nxt (acc_nxt),
      .q_bit   (q_bit)
   );

   // MIN/-1 needs no special case: |MIN|/1 yields MIN with a zero remainder.
   always_comb begin
      acc_step = acc_nxt | {{(2*XLEN-1){1'b0}}, q_bit};
      prod     = neg_res ? -acc_step : acc_step;
      quo      = neg_res ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      rem      = neg_rem ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
      res_hi   = prod[2*XLEN-1:XLEN];
      res_lo   = prod[XLEN-1:0];
      if (state == ST_DIV) begin
         if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
         end else begin
            res_hi = rem;
            res_lo = quo;
         end
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_abs;
   logic [2*XLEN-1:0] fast_prod;

   always_comb begin
      fast_abs  = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
      fast_prod = (a_neg ^ b_neg) ? -fast_abs : fast_abs;
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         a_raw    <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         hi_r     <= '0;
         lo_r     <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (flush_i) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            cnt    <= '0;
         end else begin
            case (state)
               ST_IDLE, ST_DONE: begin
                  state  <= ST_IDLE;
                  busy_r <= 1'b0;
                  if (mthi_i) hi_r <= wdata_i;
                  if (mtlo_i) lo_r <= wdata_i;
                  if (start_i) begin
                     cnt      <= '0;
                     a_raw    <= a_i;
                     div_zero <= (b_i == '0);
                     neg_res  <= a_neg ^ b_neg;
                     neg_rem  <= a_neg;
                     if (op_i[1]) begin
                        acc    <= {{XLEN{1'b0}}, abs_a};
                        opnd   <= abs_b;
                        state  <= ST_DIV;
                        busy_r <= 1'b1;
                     end else begin
                        acc    <= {{XLEN{1'b0}}, abs_b};
                        opnd   <= abs_a;
`ifdef MULDIV_FAST_MUL_EN
                        state  <= ST_DONE;
                        done_r <= 1'b1;
                        hi_r   <= fast_prod[2*XLEN-1:XLEN];
                        lo_r   <= fast_prod[XLEN-1:0];
`else
                        state  <= ST_MUL;
                        busy_r <= 1'b1;
`endif
                     end
                  end
               end
               ST_MUL, ST_DIV: begin
                  acc <= acc_step;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_LAST) begin
                     state  <= ST_DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     hi_r   <= res_hi;
                     lo_r   <= res_lo;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy_o = busy_r;
   assign done_o = done_r;
   assign hi_o   = hi_r;
   assign lo_o   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed checks of muldiv_unit against a plain-arithmetic
// reference model of MIPS HI/LO semantics.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int XLEN = 32;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            start_i;
   logic [1:0]      op_i;
   logic [XLEN-1:0] a_i;
   logic [XLEN-1:0] b_i;
   logic            flush_i;
   logic            mthi_i;
   logic            mtlo_i;
   logic [XLEN-1:0] wdata_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] hi_o;
   logic [XLEN-1:0] lo_o;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .op_i    (op_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .flush_i (flush_i),
      .mthi_i  (mthi_i),
      .mtlo_i  (mtlo_i),
      .wdata_i (wdata_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: 64-bit integer arithmetic; SV division truncates toward zero
   // and the remainder follows the dividend, as MIPS requires.
   function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
      longint      sa, sb, q, r;
      logic [63:0] t, tq, tr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         OP_MULT: begin
            t  = sa * sb;
            hi = t[63:32];
            lo = t[31:0];
         end
         OP_MULTU: begin
            t  = {32'b0, a} * {32'b0, b};
            hi = t[63:32];
            lo = t[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               hi = a;
               lo = 32'hFFFF_FFFF;
            end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               hi = 32'd0;
               lo = 32'h8000_0000;
            end else begin
               if (op == OP_DIV) begin
                  q = sa / sb;
                  r = sa % sb;
               end else begin
                  q = longint'({32'b0, a}) / longint'({32'b0, b});
                  r = longint'({32'b0, a}) % longint'({32'b0, b});
               end
               tq = q;
               tr = r;
               hi = tr[31:0];
               lo = tq[31:0];
            end
         end
      endcase
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit mt_in_done, input logic [31:0] wd);
      int k;
      int busy_cnt;
      int lat_exp;
      logic [31:0] eh, el;
      ref_op(op, a, b, eh, el);
      lat_exp = XLEN + 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!op[1]) lat_exp = 1;
`endif
      @(negedge clk_i);
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      @(negedge clk_i);
      start_i = 1'b0;
      k = 1;
      busy_cnt = 0;
      while (!done_o && k < 200) begin
         if (busy_o) busy_cnt++;
         @(negedge clk_i);
         k++;
      end
      check("done_latency", 64'(k), 64'(lat_exp));
      check("busy_cycles", 64'(busy_cnt), 64'(lat_exp - 1));
      check("busy_in_done", {63'b0, busy_o}, 64'd0);
      check("hi_result", {32'b0, hi_o}, {32'b0, eh});
      check("lo_result", {32'b0, lo_o}, {32'b0, el});
      exp_hi = eh;
      exp_lo = el;
      if (mt_in_done) begin
         mthi_i = 1'b1; wdata_i = wd;
         @(negedge clk_i);
         mthi_i = 1'b0;
         exp_hi = wd;
         check("mthi_in_done", {32'b0, hi_o}, {32'b0, exp_hi});
      end else begin
         @(negedge clk_i);
      end
      check("done_one_cycle", {63'b0, done_o}, 64'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int dones;
      rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
      flush_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0; wdata_i = '0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      check("rst_busy", {63'b0, busy_o}, 64'd0);
      check("rst_done", {63'b0, done_o}, 64'd0);
      check("rst_hi", {32'b0, hi_o}, 64'd0);
      check("rst_lo", {32'b0, lo_o}, 64'd0);

      run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7, 1'b0, '0);
      check("mult_neg_hi", {32'b0, hi_o}, 64'hFFFF_FFFF);
      check("mult_neg_lo", {32'b0, lo_o}, 64'hFFFF_FFEB);
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0);
      check("multu_max_hi", {32'b0, hi_o}, 64'hFFFF_FFFE);

      // MTLO from idle lands on the next edge.
      mtlo_i = 1'b1; wdata_i = 32'h1234_5678;
      @(negedge clk_i);
      mtlo_i = 1'b0;
      exp_lo = 32'h1234_5678;
      check("mtlo_idle", {32'b0, lo_o}, 64'h1234_5678);

      run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, '0);
      check("div_neg_lo", {32'b0, lo_o}, 64'hFFFF_FFFD);
      run_op(OP_DIVU, 32'd7, 32'd0, 1'b0, '0);
      check("divu_zero_lo", {32'b0, lo_o}, 64'hFFFF_FFFF);
      run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0);
      check("div_ovf_no_x", {32'b0, ^{hi_o, lo_o, busy_o, done_o} === 1'bx}, 64'd0);
      run_op(OP_MULT, 32'd6, 32'd7, 1'b1, 32'hCAFE_F00D);

      // Flush at iteration 10; a start and an MTHI during busy must be ignored.
      @(negedge clk_i);
      start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd3;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (2) @(negedge clk_i);
      start_i = 1'b1; op_i = OP_MULTU; mthi_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      start_i = 1'b0; mthi_i = 1'b0;
      repeat (6) @(negedge clk_i);
      check("busy_before_flush", {63'b0, busy_o}, 64'd1);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      check("flush_busy", {63'b0, busy_o}, 64'd0);
      check("flush_done", {63'b0, done_o}, 64'd0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_o) dones++;
         @(negedge clk_i);
      end
      check("flush_no_done", 64'(dones), 64'd0);
      check("flush_hi_kept", {32'b0, hi_o}, {32'b0, exp_hi});
      check("flush_lo_kept", {32'b0, lo_o}, {32'b0, exp_lo});

      for (int n = 0; n < 60; n++) begin
         logic [1:0]  rop;
         logic [31:0] ra, rb;
         rop = 2'($urandom_range(0, 3));
         ra  = pick_operand();
         rb  = pick_operand();
         run_op(rop, ra, rb, ($urandom_range(0, 3) == 0), $urandom);
      end

      // Reset in the middle of a divide drops it entirely.
      @(negedge clk_i);
      start_i = 1'b1; op_i = OP_DIV; a_i = 32'd1000; b_i = 32'd7;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (5) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("midrst_busy", {63'b0, busy_o}, 64'd0);
      check("midrst_done", {63'b0, done_o}, 64'd0);
      check("midrst_hi", {32'b0, hi_o}, 64'd0);
      check("midrst_lo", {32'b0, lo_o}, 64'd0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_o) dones++;
         @(negedge clk_i);
      end
      check("midrst_no_done", 64'(dones), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
